mul_div_unit: RTL

HI/LO multiply-divide unit for the execute stage of the five-stage MIPS pipeline. It consumes the decoder's `mulCtrl`/`mulOutputSel` control and the forwarded rs/rt operands. It runs mult/multu/div/divu/madd/maddu/msub as fixed-latency multi-cycle operations and applies mthi/mtlo immediately. It exposes `busy` to the hazard unit and the selected HI/LO word to the grfWriteMul write-back path.

---
 rtl/mul_div_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit -- HI/LO multiply/divide unit for the MIPS execute stage.
//
// Runs mult/multu/div/divu (and madd/maddu/msub when MDU_MADD_EN is defined)
// as fixed-latency multi-cycle operations. mthi/mtlo write HI/LO at the
// accepting edge without going busy.
//
// Optional feature macro: MDU_MADD_EN (accumulate ops madd/maddu/msub).
//   Undefined: those opcodes are treated like mtDisabled and no 64-bit
//   accumulator is built.
//
// Parameters:
//   MUL_LATENCY  busy cycles for multiply/accumulate ops (1..15)
//   DIV_LATENCY  busy cycles for divide ops (1..15)
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous, active-low
//   start         instruction in E is valid
//   squash        flush; blocks issue in the same cycle
//   mulCtrl       4-bit opcode (mt* encodings below)
//   mulOutputSel  1 = HI, 0 = LO on out
//   operandA/B    forwarded rs/rt
//   busy          multi-cycle op in flight
//   out           selected HI or LO
//   hi, lo        raw HI/LO registers
module mul_div_unit #(
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned DIV_LATENCY = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        squash,
  input  logic [3:0]  mulCtrl,
  input  logic        mulOutputSel,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Opcode encodings shared with the decoder.
  localparam logic [3:0] MT_DISABLED = 4'd0;
  localparam logic [3:0] MT_MULT     = 4'd1;
  localparam logic [3:0] MT_MULTU    = 4'd2;
  localparam logic [3:0] MT_DIV      = 4'd3;
  localparam logic [3:0] MT_DIVU     = 4'd4;
  localparam logic [3:0] MT_MADD     = 4'd5;
  localparam logic [3:0] MT_MADDU    = 4'd6;
  localparam logic [3:0] MT_MSUB     = 4'd7;
  localparam logic [3:0] MT_SETHI    = 4'd8;
  localparam logic [3:0] MT_SETLO    = 4'd9;

  localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
  localparam logic [3:0] DIV_LAT = 4'(DIV_LATENCY);

`ifdef MDU_MADD_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------- decode
  logic op_mul, op_div, op_acc;
  logic can_issue, issue_mc, issue_set_hi, issue_set_lo, done;

  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_acc = 1'b0;
    case (mulCtrl)
      MT_MULT, MT_MULTU:          op_mul = 1'b1;
      MT_DIV, MT_DIVU:            op_div = 1'b1;
      MT_MADD, MT_MADDU, MT_MSUB: op_acc = ACC_EN;
      default:                    ;
    endcase
  end

  // mulCtrl == MT_DISABLED and unknown codes simply fail every decode term.
  assign can_issue    = start && !squash && (state_q == S_IDLE);
  assign issue_mc     = can_issue && (op_mul || op_div || op_acc);
  assign issue_set_hi = can_issue && (mulCtrl == MT_SETHI);
  assign issue_set_lo = can_issue && (mulCtrl == MT_SETLO);
  assign done         = (state_q == S_BUSY) && (cnt_q == 4'd1);

  // ------------------------------------------------------------- arithmetic
  // Low 64 bits of a product of sign-extended operands equal the signed
  // 32x32 product, so one unsigned 64-bit multiply form serves both.
  logic [63:0] a_sext, b_sext, prod_s, prod_u;
  assign a_sext = {{32{opa_q[31]}}, opa_q};
  assign b_sext = {{32{opb_q[31]}}, opb_q};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, opa_q} * {32'd0, opb_q};

  // One unsigned divider; signed divide works on magnitudes and fixes signs.
  // 0x80000000 / -1 falls out naturally: |a| = 0x80000000, |b| = 1, and
  // negating 0x80000000 leaves it unchanged, remainder 0.
  logic        div_signed;
  logic [31:0] abs_a, abs_b, div_n, div_d, q_mag, r_mag, quo, rem;

  always_comb begin
    div_signed = (op_q == MT_DIV);
    abs_a = opa_q[31] ? (~opa_q + 32'd1) : opa_q;
    abs_b = opb_q[31] ? (~opb_q + 32'd1) : opb_q;
    div_n = div_signed ? abs_a : opa_q;
    div_d = div_signed ? abs_b : opb_q;
    // Zero divisor is overridden in the result mux; avoid a /0 here.
    q_mag = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    r_mag = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    quo = q_mag;
    rem = r_mag;
    if (div_signed) begin
      if (opa_q[31] ^ opb_q[31]) quo = ~q_mag + 32'd1;
      if (opa_q[31])             rem = ~r_mag + 32'd1;  // sign follows dividend
    end
  end

  logic [63:0] result;

  always_comb begin
    result = {hi_q, lo_q};
    case (op_q)
      MT_MULT:  result = prod_s;
      MT_MULTU: result = prod_u;
      MT_DIV, MT_DIVU: begin
        if (opb_q == 32'd0) result = {opa_q, 32'hFFFF_FFFF};
        else                result = {rem, quo};
      end
`ifdef MDU_MADD_EN
      // HI/LO are frozen while busy, so the completion-time value is the
      // issue-time accumulator.
      MT_MADD:  result = {hi_q, lo_q} + prod_s;
      MT_MADDU: result = {hi_q, lo_q} + prod_u;
      MT_MSUB:  result = {hi_q, lo_q} - prod_s;
`endif
      default:  ;
    endcase
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= MT_DISABLED;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_mc) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 4'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch on issue, count down while busy, write
  // HI/LO on the last busy edge. mt* writes only happen from IDLE, so they
  // never collide with a completion.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    opa_d = opa_q;
    opb_d = opb_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (issue_mc) begin
      cnt_d = op_div ? DIV_LAT : MUL_LAT;
      op_d  = mulCtrl;
      opa_d = operandA;
      opb_d = operandB;
    end
    if (issue_set_hi) hi_d = operandA;
    if (issue_set_lo) lo_d = operandA;
    if (state_q == S_BUSY) cnt_d = cnt_q - 4'd1;
    if (done) {hi_d, lo_d} = result;
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    busy = (state_q == S_BUSY);
    hi   = hi_q;
    lo   = lo_q;
    out  = mulOutputSel ? hi_q : lo_q;
  end

endmodule
